// File: rtl/shiftreg_seq_pkg.sv
// ---------------------------------------------------------------------------
// shiftreg_seq_pkg : select/op codes, state encodings and helpers for the
//                    shift-register command sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package shiftreg_seq_pkg;

   localparam logic [1:0] SEL_HOLD = 2'b00;
   localparam logic [1:0] SEL_SHR  = 2'b01;
   localparam logic [1:0] SEL_SHL  = 2'b10;
   localparam logic [1:0] SEL_LOAD = 2'b11;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_SHR   = 2'b01;
   localparam logic [1:0] OP_SHL   = 2'b10;
   localparam logic [1:0] OP_ROT   = 2'b11;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   // ROT borrows the fill bit as its direction: 1 = left, 0 = right.
   function automatic logic [1:0] op_sel(input logic [1:0] op, input logic dir_left);
      case (op)
         OP_LOAD: return SEL_LOAD;
         OP_SHR:  return SEL_SHR;
         OP_SHL:  return SEL_SHL;
         default: return dir_left ? SEL_SHL : SEL_SHR;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/shiftreg_seq_if.sv
// ---------------------------------------------------------------------------
// shiftreg_seq_if : command handshake plus shift-register drive/feedback bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface shiftreg_seq_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [CNT_W-1:0] cmd_cnt;
   logic [WIDTH-1:0] cmd_data;
   logic             cmd_fill;
   logic [WIDTH-1:0] q_in;
   logic [1:0]       s;
   logic [WIDTH-1:0] d;
   logic             Lin;
   logic             Rin;
   logic             busy;
   logic             done;

   modport master (
      output cmd_valid, cmd_op, cmd_cnt, cmd_data, cmd_fill,
      input  cmd_ready, q_in, s, d, Lin, Rin, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_cnt, cmd_data, cmd_fill, q_in,
      output cmd_ready, s, d, Lin, Rin, busy, done
   );
endinterface

`default_nettype wire

// File: rtl/shiftreg_seq_cnt.sv
// ---------------------------------------------------------------------------
// shiftreg_seq_cnt : loadable down-counter with zero flag; saturates at zero
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shiftreg_seq_cnt #(
   parameter int CNT_W = 3
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);
   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && (cnt_q != '0))
         cnt_d = cnt_q - ONE;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);
endmodule

`default_nettype wire

// File: rtl/shiftreg_u.sv
// ---------------------------------------------------------------------------
// shiftreg_u : universal shift register (hold / shift right / shift left / load)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shiftreg_u
   import shiftreg_seq_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [1:0]       s_i,
   input  logic [WIDTH-1:0] d_i,
   input  logic             lin_i,
   input  logic             rin_i,
   output logic [WIDTH-1:0] q_o
);
   logic [WIDTH-1:0] q_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         q_q <= '0;
      end else begin
         case (s_i)
            SEL_SHR:  q_q <= {lin_i, q_q[WIDTH-1:1]};
            SEL_SHL:  q_q <= {q_q[WIDTH-2:0], rin_i};
            SEL_LOAD: q_q <= d_i;
            default:  q_q <= q_q;
         endcase
      end
   end

   assign q_o = q_q;
endmodule

`default_nettype wire

// File: rtl/shiftreg_seq.sv
// ---------------------------------------------------------------------------
// shiftreg_seq : load/shift/rotate command sequencer driving shiftreg_u
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shiftreg_seq
   import shiftreg_seq_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic          clk_i,
   input  logic          reset_i,
   shiftreg_seq_if.slave bus
);
   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [1:0]       op_q,    op_d;
   logic             fill_q,  fill_d;
   logic [1:0]       s_q,     s_d;
   logic [WIDTH-1:0] data_q,  data_d;

   logic             w_ready;
   logic             w_accept;
   logic             w_zero_cnt;
   logic             w_rem_zero;
   logic [CNT_W-1:0] w_rem_init;
   logic             w_lin;
   logic             w_rin;

   assign w_ready    = (state_q == ST_IDLE) && !reset_i;
   assign w_accept   = bus.cmd_valid && w_ready;
   assign w_zero_cnt = (bus.cmd_op != OP_LOAD) && (bus.cmd_cnt == '0);
   assign w_rem_init = ((bus.cmd_op == OP_LOAD) || w_zero_cnt) ? '0 : bus.cmd_cnt - ONE;

   shiftreg_seq_cnt #(.CNT_W(CNT_W)) u_rem (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .load_i     (w_accept),
      .load_val_i (w_rem_init),
      .dec_i      (state_q == ST_RUN),
      .zero_o     (w_rem_zero)
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         op_q    <= OP_LOAD;
         fill_q  <= 1'b0;
         s_q     <= SEL_HOLD;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         fill_q  <= fill_d;
         s_q     <= s_d;
         data_q  <= data_d;
      end
   end

   // A zero-count command spends its single RUN cycle with s held at 00,
   // so done lands one cycle after acceptance just like a LOAD.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      fill_d  = fill_q;
      s_d     = s_q;
      data_d  = data_q;
      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               state_d = ST_RUN;
               op_d    = bus.cmd_op;
               fill_d  = bus.cmd_fill;
               data_d  = bus.cmd_data;
               s_d     = w_zero_cnt ? SEL_HOLD : op_sel(bus.cmd_op, bus.cmd_fill);
            end
         end
         ST_RUN: begin
            if (w_rem_zero) begin
               state_d = ST_DONE;
               s_d     = SEL_HOLD;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: begin
            state_d = ST_IDLE;
            s_d     = SEL_HOLD;
         end
      endcase
   end

   // Rotations feed back the live register so every step sees the current q.
   always_comb begin
      w_lin = 1'b0;
      w_rin = 1'b0;
      if (state_q == ST_RUN) begin
         if (s_q == SEL_SHR)
            w_lin = (op_q == OP_ROT) ? bus.q_in[0] : fill_q;
         if (s_q == SEL_SHL)
            w_rin = (op_q == OP_ROT) ? bus.q_in[WIDTH-1] : fill_q;
      end
   end

   assign bus.cmd_ready = w_ready;
   assign bus.s         = s_q;
   assign bus.d         = data_q;
   assign bus.Lin       = w_lin;
   assign bus.Rin       = w_rin;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.done      = (state_q == ST_DONE);
endmodule

`default_nettype wire

// File: tb/tb_shiftreg_seq.sv
// ---------------------------------------------------------------------------
// tb_shiftreg_seq : self-checking bench for shiftreg_seq driving shiftreg_u
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_shiftreg_seq;
   localparam int W = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] q;
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_err = 0;
   logic [3:0] q_model = 4'h0;

   shiftreg_seq_if #(.WIDTH(W), .CNT_W(3)) ifc ();

   shiftreg_seq #(.WIDTH(W), .CNT_W(3)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (ifc.slave)
   );

   shiftreg_u #(.WIDTH(W)) u_reg (
      .clk_i   (clk),
      .rst_n_i (~reset),
      .s_i     (ifc.s),
      .d_i     (ifc.d),
      .lin_i   (ifc.Lin),
      .rin_i   (ifc.Rin),
      .q_o     (q)
   );

   assign ifc.q_in = q;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [1:0] op;
      logic [2:0] cnt;
      logic [3:0] data;
      logic       fill;
      logic [3:0] exp_q;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Reference: final register value from the command's arithmetic meaning.
   function automatic logic [3:0] model(input logic [3:0] qv, input logic [1:0] op,
                                        input logic [2:0] cnt, input logic [3:0] data,
                                        input logic fill);
      int qi = int'(qv);
      int n  = int'(cnt);
      int k  = n % W;
      int r;
      case (op)
         2'd0: r = int'(data);
         2'd1: r = (n >= W) ? (fill ? 15 : 0) : ((qi >> n) | (fill ? ((15 << (W - n)) & 15) : 0));
         2'd2: r = ((qi << n) | (fill ? ((1 << n) - 1) : 0)) & 15;
         default: r = fill ? (((qi << k) | (qi >> (W - k))) & 15)
                           : (((qi >> k) | (qi << (W - k))) & 15);
      endcase
      return r[3:0];
   endfunction

   task automatic send(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data,
                       input logic fill, output int t_acc);
      @(negedge clk);
      ifc.cmd_valid = 1'b1;
      ifc.cmd_op    = op;
      ifc.cmd_cnt   = cnt;
      ifc.cmd_data  = data;
      ifc.cmd_fill  = fill;
      for (int i = 0; i < 30 && !ifc.cmd_ready; i++) @(negedge clk);
      check("accept_wait", {31'd0, ifc.cmd_ready}, 32'd1);
      @(posedge clk);
      #1;
      t_acc = cyc;
   endtask

   // Called at accept edge + 1; follows the command until ready returns.
   task automatic observe(input string nm, input logic [1:0] op, input logic [2:0] cnt,
                          input logic fill, input logic [3:0] exp_q);
      int         n       = (op == 2'd0) ? 1 : int'(cnt);
      int         lat_exp = (n == 0) ? 1 : n;
      int         lat     = -1;
      int         s_cnt   = 0;
      logic       sel_ok  = 1'b1;
      logic       pin_ok  = 1'b1;
      logic       lin_e, rin_e;
      logic [1:0] sel_exp;
      case (op)
         2'd0:    sel_exp = 2'b11;
         2'd1:    sel_exp = 2'b01;
         2'd2:    sel_exp = 2'b10;
         default: sel_exp = fill ? 2'b10 : 2'b01;
      endcase
      for (int k = 0; k < 20; k++) begin
         if (ifc.s != 2'b00) begin
            s_cnt++;
            if (ifc.s !== sel_exp) sel_ok = 1'b0;
         end
         lin_e = 1'b0;
         rin_e = 1'b0;
         if (k < n) begin
            case (op)
               2'd1: lin_e = fill;
               2'd2: rin_e = fill;
               2'd3: if (fill) rin_e = q[3]; else lin_e = q[0];
               default: ;
            endcase
         end
         if (ifc.Lin !== lin_e || ifc.Rin !== rin_e) pin_ok = 1'b0;
         if (ifc.done === 1'b1) begin
            lat = k;
            break;
         end
         @(posedge clk);
         #1;
      end
      check({nm, ".done_latency"}, lat, lat_exp);
      check({nm, ".s_active_cycles"}, s_cnt, n);
      check({nm, ".s_code"}, {31'd0, sel_ok}, 32'd1);
      check({nm, ".lin_rin"}, {31'd0, pin_ok}, 32'd1);
      @(posedge clk);
      #1;
      check({nm, ".ready_done_busy"}, {29'd0, ifc.cmd_ready, ifc.done, ifc.busy}, 32'b100);
      check({nm, ".q"}, {28'd0, q}, {28'd0, exp_q});
   endtask

   task automatic run_one(input string nm, input logic [1:0] op, input logic [2:0] cnt,
                          input logic [3:0] data, input logic fill, input logic [3:0] exp_q);
      int t;
      send(op, cnt, data, fill, t);
      ifc.cmd_valid = 1'b0;
      observe(nm, op, cnt, fill, exp_q);
      q_model = exp_q;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         t1, t2;
      logic [1:0] r_op;
      logic [2:0] r_cnt;
      logic [3:0] r_data, r_exp;
      logic       r_fill;

      vecs[0] = '{op: 2'd0, cnt: 3'd0, data: 4'b0101, fill: 1'b0, exp_q: 4'b0101};
      vecs[1] = '{op: 2'd1, cnt: 3'd2, data: 4'b0000, fill: 1'b1, exp_q: 4'b1101};
      vecs[2] = '{op: 2'd0, cnt: 3'd5, data: 4'b0101, fill: 1'b0, exp_q: 4'b0101};
      vecs[3] = '{op: 2'd3, cnt: 3'd3, data: 4'b1111, fill: 1'b1, exp_q: 4'b1010};
      vecs[4] = '{op: 2'd3, cnt: 3'd4, data: 4'b0000, fill: 1'b0, exp_q: 4'b1010};
      vecs[5] = '{op: 2'd2, cnt: 3'd0, data: 4'b1111, fill: 1'b1, exp_q: 4'b1010};
      vecs[6] = '{op: 2'd0, cnt: 3'd0, data: 4'b1111, fill: 1'b0, exp_q: 4'b1111};
      vecs[7] = '{op: 2'd2, cnt: 3'd7, data: 4'b0000, fill: 1'b0, exp_q: 4'b0000};

      ifc.cmd_valid = 1'b0;
      ifc.cmd_op    = 2'd0;
      ifc.cmd_cnt   = 3'd0;
      ifc.cmd_data  = 4'd0;
      ifc.cmd_fill  = 1'b0;

      #12;
      check("reset.outputs", {ifc.cmd_ready, ifc.s, ifc.d, ifc.Lin, ifc.Rin, ifc.done, ifc.busy}, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("reset.ready_after_release", {31'd0, ifc.cmd_ready}, 32'd1);

      for (int i = 0; i < 8; i++)
         run_one($sformatf("vec%0d", i), vecs[i].op, vecs[i].cnt, vecs[i].data,
                 vecs[i].fill, vecs[i].exp_q);

      // Two commands presented back-to-back with cmd_valid held high.
      send(2'd0, 3'd0, 4'b0011, 1'b0, t1);
      ifc.cmd_op   = 2'd1;
      ifc.cmd_cnt  = 3'd1;
      ifc.cmd_data = 4'b1100;
      ifc.cmd_fill = 1'b0;
      observe("b2b.load", 2'd0, 3'd0, 1'b0, 4'b0011);
      @(posedge clk);
      #1;
      t2 = cyc;
      ifc.cmd_valid = 1'b0;
      check("b2b.accept_gap", t2 - t1, 3);
      observe("b2b.shr", 2'd1, 3'd1, 1'b0, 4'b0001);

      // Reset asserted two cycles into a SHL of 5.
      run_one("pre_abort.load", 2'd0, 3'd0, 4'b1001, 1'b0, 4'b1001);
      send(2'd2, 3'd5, 4'b0000, 1'b1, t1);
      ifc.cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("abort.outputs", {ifc.cmd_ready, ifc.s, ifc.d, ifc.Lin, ifc.Rin, ifc.done, ifc.busy}, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort.ready_after_release", {30'd0, ifc.cmd_ready, ifc.done}, 32'b10);
      q_model = 4'h0;
      run_one("post_abort.load", 2'd0, 3'd0, 4'b0110, 1'b0, 4'b0110);
      run_one("post_abort.rotl", 2'd3, 3'd1, 4'b0000, 1'b1, model(q_model, 2'd3, 3'd1, 4'b0, 1'b1));

      for (int i = 0; i < 30; i++) begin
         r_op   = 2'($urandom_range(0, 3));
         r_cnt  = 3'($urandom_range(0, 7));
         r_data = 4'($urandom);
         r_fill = 1'($urandom);
         r_exp  = model(q_model, r_op, r_cnt, r_data, r_fill);
         run_one($sformatf("rnd%0d_op%0d_c%0d", i, r_op, r_cnt), r_op, r_cnt, r_data, r_fill, r_exp);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

`default_nettype wire
